// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between IF prefetch and MEM-stage data.
// Optional IF anti-starvation guard enabled by defining MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter int StarveLimit  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_IFRequest,
    input  logic [AddressWidth-1:0] in_IFAddress,
    input  logic                    in_IFFlush,
    output logic [DataWidth-1:0]    out_IFInstruction,
    output logic                    out_IFWait,
    input  logic                    in_DRequest,
    input  logic                    in_DWrite,
    input  logic [AddressWidth-1:0] in_DAddress,
    input  logic [DataWidth-1:0]    in_DWriteData,
    output logic [DataWidth-1:0]    out_DReadData,
    output logic                    out_DWait,
    output logic                    out_MemRequest,
    output logic                    out_MemWrite,
    output logic [AddressWidth-1:0] out_MemAddress,
    output logic [DataWidth-1:0]    out_MemWriteData,
    input  logic [DataWidth-1:0]    in_MemReadData,
    input  logic                    in_MemReady
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        IF_BUSY    = 2'd1,
        D_BUSY     = 2'd2,
        IF_DISCARD = 2'd3
    } state_t;

    localparam logic [AddressWidth-1:0] WordMask = ~AddressWidth'(3);

    if (StarveLimit < 1 || StarveLimit > 15) begin : g_bad_limit
        $error("StarveLimit must be in 1..15");
    end

    state_t state;
    logic   if_ok;
    logic   take_d;
    logic   take_if;
    logic   starved;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    logic [3:0] starve;

    assign starved = (starve == 4'(StarveLimit));

    // Count D grants that overtook a waiting IF; cleared when IF finally wins
    always_ff @(posedge clock) begin
        if (reset) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (take_if) begin
                starve <= '0;
            end else if (take_d && in_IFRequest && !starved) begin
                starve <= starve + 4'd1;
            end
        end
    end
`else
    assign starved = 1'b0;
`endif

    // Arbitration: D wins unless the guard says IF has waited long enough
    always_comb begin
        if_ok   = in_IFRequest & ~in_IFFlush;
        take_d  = in_DRequest & ~(starved & if_ok);
        take_if = if_ok & ~take_d;
    end

    // Completion handshakes and read-data pass-through
    always_comb begin
        out_IFWait = in_IFRequest
                   & ~((state == IF_BUSY) & in_MemReady & ~in_IFFlush);
        out_DWait  = in_DRequest & ~((state == D_BUSY) & in_MemReady);
        out_IFInstruction = in_MemReadData;
        out_DReadData     = in_MemReadData;
    end

    // Access sequencer with registered memory-side outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            out_MemRequest   <= 1'b0;
            out_MemWrite     <= 1'b0;
            out_MemAddress   <= '0;
            out_MemWriteData <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_d) begin
                        out_MemRequest   <= 1'b1;
                        out_MemWrite     <= in_DWrite;
                        out_MemAddress   <= in_DAddress;
                        out_MemWriteData <= in_DWriteData;
                        state            <= D_BUSY;
                    end else if (take_if) begin
                        out_MemRequest <= 1'b1;
                        out_MemWrite   <= 1'b0;
                        out_MemAddress <= in_IFAddress & WordMask;
                        state          <= IF_BUSY;
                    end else begin
                        out_MemRequest <= 1'b0;
                    end
                end
                IF_BUSY: begin
                    if (in_MemReady) begin
                        out_MemRequest <= 1'b0;
                        state          <= IDLE;
                    end else if (in_IFFlush) begin
                        state <= IF_DISCARD;
                    end
                end
                D_BUSY, IF_DISCARD: begin
                    if (in_MemReady) begin
                        out_MemRequest <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    out_MemRequest <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus a starvation sequence.
// Expected grant order depends on MEM_PORT_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    typedef struct {
        string       name;
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        fl;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] rd;
        logic        rdy;
        logic        e_mreq;
        logic        e_mwr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic        chk_a;
        logic        chk_d;
        logic        e_ifw;
        logic        e_dw;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_IFRequest;
    logic [31:0] in_IFAddress;
    logic        in_IFFlush;
    logic [31:0] out_IFInstruction;
    logic        out_IFWait;
    logic        in_DRequest;
    logic        in_DWrite;
    logic [31:0] in_DAddress;
    logic [31:0] in_DWriteData;
    logic [31:0] out_DReadData;
    logic        out_DWait;
    logic        out_MemRequest;
    logic        out_MemWrite;
    logic [31:0] out_MemAddress;
    logic [31:0] out_MemWriteData;
    logic [31:0] in_MemReadData;
    logic        in_MemReady;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vq[$];

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .AddressWidth(32),
        .DataWidth(32),
        .StarveLimit(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_IFRequest(in_IFRequest),
        .in_IFAddress(in_IFAddress),
        .in_IFFlush(in_IFFlush),
        .out_IFInstruction(out_IFInstruction),
        .out_IFWait(out_IFWait),
        .in_DRequest(in_DRequest),
        .in_DWrite(in_DWrite),
        .in_DAddress(in_DAddress),
        .in_DWriteData(in_DWriteData),
        .out_DReadData(out_DReadData),
        .out_DWait(out_DWait),
        .out_MemRequest(out_MemRequest),
        .out_MemWrite(out_MemWrite),
        .out_MemAddress(out_MemAddress),
        .out_MemWriteData(out_MemWriteData),
        .in_MemReadData(in_MemReadData),
        .in_MemReady(in_MemReady)
    );

    task automatic add(
        input string nm,
        input logic rst, input logic ifr, input logic [31:0] ifa,
        input logic fl, input logic dr, input logic dw,
        input logic [31:0] da, input logic [31:0] dwd,
        input logic [31:0] rd, input logic rdy,
        input logic mreq, input logic mwr, input logic [31:0] maddr,
        input logic [31:0] mwd, input logic ca, input logic cd,
        input logic ifw, input logic dwt
    );
        vec_t v;
        v.name = nm;  v.rst = rst;  v.ifr = ifr;  v.ifa = ifa;
        v.fl = fl;    v.dr = dr;    v.dw = dw;    v.da = da;
        v.dwd = dwd;  v.rd = rd;    v.rdy = rdy;
        v.e_mreq = mreq;  v.e_mwr = mwr;  v.e_maddr = maddr;
        v.e_mwd = mwd;    v.chk_a = ca;   v.chk_d = cd;
        v.e_ifw = ifw;    v.e_dw = dwt;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset          = v.rst;
        in_IFRequest   = v.ifr;
        in_IFAddress   = v.ifa;
        in_IFFlush     = v.fl;
        in_DRequest    = v.dr;
        in_DWrite      = v.dw;
        in_DAddress    = v.da;
        in_DWriteData  = v.dwd;
        in_MemReadData = v.rd;
        in_MemReady    = v.rdy;
    endtask

    task automatic check(input vec_t v);
        bit bad;
        bad = 1'b0;
        if (out_MemRequest !== v.e_mreq) bad = 1'b1;
        if (out_IFWait !== v.e_ifw) bad = 1'b1;
        if (out_DWait !== v.e_dw) bad = 1'b1;
        if (out_IFInstruction !== v.rd) bad = 1'b1;
        if (out_DReadData !== v.rd) bad = 1'b1;
        if (v.chk_a && (out_MemAddress !== v.e_maddr)) bad = 1'b1;
        if (v.chk_a && (out_MemWrite !== v.e_mwr)) bad = 1'b1;
        if (v.chk_d && (out_MemWriteData !== v.e_mwd)) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got req=%b wr=%b addr=%h wd=%h ifw=%b dw=%b ins=%h rdd=%h; want req=%b wr=%b addr=%h wd=%h ifw=%b dw=%b ins=%h (addr chk %b, data chk %b)",
                     v.name, out_MemRequest, out_MemWrite, out_MemAddress,
                     out_MemWriteData, out_IFWait, out_DWait,
                     out_IFInstruction, out_DReadData,
                     v.e_mreq, v.e_mwr, v.e_maddr, v.e_mwd, v.e_ifw,
                     v.e_dw, v.rd, v.chk_a, v.chk_d);
        end
    endtask

    initial begin
        string got;
        string want;

        // Reset check
        add("rst_hold", 1,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,1, 0,0);
        // IF only, unaligned address, ready on first busy cycle
        add("if_idle", 0,1,'h103,0,0,0,0,0,0,0, 0,0,0,0,1,1, 1,0);
        add("if_done", 0,1,'h103,0,0,0,0,0,'hE3A01005,1, 1,0,'h100,0,1,1, 0,0);
        add("if_after", 0,0,0,0,0,0,0,0,0,0, 0,0,'h100,0,1,1, 0,0);
        // Simultaneous IF and D load
        add("both_idle", 0,1,'h200,0,1,0,'h1000,0,0,0, 0,0,'h100,0,1,1, 1,1);
        add("both_d_done", 0,1,'h200,0,1,0,'h1000,0,'h11112222,1, 1,0,'h1000,0,1,1, 1,0);
        add("both_if_grant", 0,1,'h200,0,0,0,0,0,0,0, 0,0,'h1000,0,1,1, 1,0);
        add("both_if_done", 0,1,'h200,0,0,0,0,0,'h33334444,1, 1,0,'h200,0,1,0, 0,0);
        // D store with three wait cycles
        add("st_idle", 0,0,0,0,1,1,'h2000,'hDEADBEEF,0,0, 0,0,'h200,0,1,0, 0,1);
        add("st_busy1", 0,0,0,0,1,1,'h2000,'hDEADBEEF,0,0, 1,1,'h2000,'hDEADBEEF,1,1, 0,1);
        add("st_busy2", 0,0,0,0,1,1,'h2000,'hDEADBEEF,0,0, 1,1,'h2000,'hDEADBEEF,1,1, 0,1);
        add("st_busy3", 0,0,0,0,1,1,'h2000,'hDEADBEEF,0,0, 1,1,'h2000,'hDEADBEEF,1,1, 0,1);
        add("st_done", 0,0,0,0,1,1,'h2000,'hDEADBEEF,'h0BAD0BAD,1, 1,1,'h2000,'hDEADBEEF,1,1, 0,0);
        add("st_after", 0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0);
        // Flush in 2nd cycle of a 4-cycle IF access
        add("fl_idle", 0,1,'h300,0,0,0,0,0,0,0, 0,0,0,0,0,0, 1,0);
        add("fl_busy1", 0,1,'h300,0,0,0,0,0,0,0, 1,0,'h300,0,1,0, 1,0);
        add("fl_busy2", 0,1,'h400,1,0,0,0,0,0,0, 1,0,'h300,0,1,0, 1,0);
        add("fl_busy3", 0,1,'h400,0,0,0,0,0,0,0, 1,0,'h300,0,1,0, 1,0);
        add("fl_busy4", 0,1,'h400,0,0,0,0,0,'h55556666,1, 1,0,'h300,0,1,0, 1,0);
        add("fl_regrant", 0,1,'h400,0,0,0,0,0,0,0, 0,0,'h300,0,1,0, 1,0);
        add("fl_new_done", 0,1,'h400,0,0,0,0,0,'h77778888,1, 1,0,'h400,0,1,0, 0,0);
        // Flush in the ready cycle, then flush in IDLE
        add("fr_idle", 0,1,'h500,0,0,0,0,0,0,0, 0,0,'h400,0,1,0, 1,0);
        add("fr_ready", 0,1,'h500,1,0,0,0,0,'h9999AAAA,1, 1,0,'h500,0,1,0, 1,0);
        add("fi_flush", 0,1,'h600,1,0,0,0,0,0,0, 0,0,'h500,0,1,0, 1,0);
        add("fi_nogrant", 0,0,0,0,0,0,0,0,0,0, 0,0,'h500,0,1,0, 0,0);
        // Reset during D_BUSY
        add("rs_idle", 0,0,0,0,1,0,'h3000,0,0,0, 0,0,'h500,0,1,0, 0,1);
        add("rs_busy", 1,0,0,0,1,0,'h3000,0,0,0, 1,0,'h3000,0,1,1, 0,1);
        add("rs_after", 0,0,0,0,1,0,'h3000,0,'h0000CCCC,1, 0,0,0,0,1,1, 0,1);
        add("rs_redone", 0,0,0,0,1,0,'h3000,0,'hCCCCDDDD,1, 1,0,'h3000,0,1,1, 0,0);
        add("rs_end", 0,0,0,0,0,0,0,0,0,0, 0,0,'h3000,0,1,1, 0,0);

        drive(vq[0]);
        repeat (2) @(posedge clock);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clock);
            drive(vq[i]);
            #1;
            check(vq[i]);
        end

        // Both sides request continuously with an always-ready memory
        got = "";
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
        want = "DDDDIDDDDI";
`else
        want = "DDDDDDDDDD";
`endif
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            reset          = 1'b0;
            in_IFRequest   = 1'b1;
            in_IFAddress   = 32'h700;
            in_IFFlush     = 1'b0;
            in_DRequest    = 1'b1;
            in_DWrite      = 1'b0;
            in_DAddress    = 32'h4000;
            in_DWriteData  = 32'h0;
            in_MemReadData = 32'h0;
            in_MemReady    = 1'b1;
            #1;
            if (!out_IFWait) got = {got, "I"};
            if (!out_DWait) got = {got, "D"};
        end
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL starve_order: got %s want %s", got, want);
        end

        @(negedge clock);
        in_IFRequest = 1'b0;
        in_DRequest  = 1'b0;
        in_MemReady  = 1'b0;
        repeat (2) @(posedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
